// File: rtl/axi_tensor_fetch.sv
// AXI4 read master: splits a tensor fetch into 4 KB-safe INCR bursts and streams
// the returned beats out of a credit-reserved FIFO.
module axi_tensor_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LOG2B = $clog2(BYTES);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_CRED, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [15:0]           r_rem_q, r_rem_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  m_valid_q, m_valid_d;
  logic                  rready_q, rready_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  ar_hs, push, pop, r_last_exp;
  logic [8:0]            issue_blen, start_blen, r_blen, burst_len;
  logic [ADDR_WIDTH-1:0] base_al;
  logic                  unused_rid;

  // Burst length bounded by remaining beats, MAX_BURST and the 4 KB page end.
  function automatic logic [8:0] calc_blen(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [15:0] rem);
    logic [12:0] page_beats;
    logic [16:0] b;
    page_beats = (13'd4096 - {1'b0, a[11:0]}) >> LOG2B;
    b = {1'b0, rem};
    if (b > 17'(MAX_BURST)) b = 17'(MAX_BURST);
    if (b > 17'(page_beats)) b = 17'(page_beats);
    return 9'(b);
  endfunction

  assign base_al    = base_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign ar_hs      = arvalid_q && m_axi_arready;
  // Beats outside a transfer (e.g. left over from an abandoned one) are discarded.
  assign push       = m_axi_rvalid && rready_q && busy_q && (r_rem_q != 16'd0);
  assign pop        = m_valid_q && m_ready;
  assign issue_blen = calc_blen(addr_q, rem_q);
  assign start_blen = calc_blen(base_al, num_beats);
  assign r_blen     = calc_blen(r_addr_q, r_rem_q);
  assign burst_len  = 9'(arlen_q) + 9'd1;
  assign r_last_exp = (9'(r_beat_q) + 9'd1) == r_blen;
  assign unused_rid = ^m_axi_rid;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    r_addr_d  = r_addr_q;
    r_rem_d   = r_rem_q;
    r_beat_d  = r_beat_q;
    credits_d = credits_q - (ar_hs ? CW'(burst_len) : CW'(0)) + CW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);

    // R side replays the burst split to know where each rlast belongs.
    if (push) begin
      if (m_axi_rresp != 2'b00) err_d = 1'b1;
      if (m_axi_rlast != r_last_exp) err_d = 1'b1;
      if (r_last_exp) begin
        r_addr_d = r_addr_q + (ADDR_WIDTH'(r_blen) << LOG2B);
        r_rem_d  = r_rem_q - 16'(r_blen);
        r_beat_d = 8'd0;
      end else begin
        r_beat_d = r_beat_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_beats == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            addr_d    = base_al;
            rem_d     = num_beats;
            r_addr_d  = base_al;
            r_rem_d   = num_beats;
            r_beat_d  = 8'd0;
            arvalid_d = 1'b1;
            araddr_d  = base_al;
            arlen_d   = 8'(start_blen - 9'd1);
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (arvalid_q) begin
          if (m_axi_arready) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + (ADDR_WIDTH'(burst_len) << LOG2B);
            rem_d     = rem_q - 16'(burst_len);
            state_d   = (rem_q == 16'(burst_len)) ? S_DRAIN : S_ISSUE;
          end
        end else if (17'(credits_q) >= 17'(issue_blen)) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(issue_blen - 9'd1);
        end else begin
          state_d = S_WAIT_CRED;
        end
      end
      S_WAIT_CRED: begin
        if (17'(credits_q) >= 17'(issue_blen)) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (r_rem_d == 16'd0 && count_d == CW'(0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    m_valid_d = (count_d != CW'(0));
    rready_d  = (count_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      r_addr_q  <= '0;
      r_rem_q   <= '0;
      r_beat_q  <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      rready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      r_addr_q  <= r_addr_d;
      r_rem_q   <= r_rem_d;
      r_beat_q  <= r_beat_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
      rready_q  <= rready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= m_axi_rdata;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(LOG2B);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_valid       = m_valid_q;
  assign m_dat         = m_valid_q ? mem_q[rd_ptr_q] : '0;

endmodule
